// File: rtl/n64_response_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | n64_response_receiver                                                    |
// | Decodes the controller's 32-bit reply plus stop bit from the shared line.|
// | Optional: define N64_RX_FIELDS_EN for buttons / stick_x / stick_y ports. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module n64_response_receiver #(
    parameter int CLKS_PER_US = 50,
    parameter int NUM_BITS    = 32,
    parameter int TIMEOUT_US  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                controller_signal,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_err,
    output logic                busy
`ifdef N64_RX_FIELDS_EN
    ,
    output logic [15:0]         buttons,
    output logic [7:0]          stick_x,
    output logic [7:0]          stick_y
`endif
);

    localparam int c_TMO_CYC = TIMEOUT_US * CLKS_PER_US;
    localparam int c_TMO_W   = $clog2(c_TMO_CYC);
    localparam int c_PH_W    = $clog2(4 * CLKS_PER_US);
    localparam int c_BIT_W   = $clog2(NUM_BITS + 1);

    localparam logic [c_TMO_W-1:0] c_TMO_MAX   = c_TMO_W'(c_TMO_CYC - 1);
    localparam logic [c_PH_W-1:0]  c_PH_SAMPLE = c_PH_W'(2 * CLKS_PER_US - 1);
    localparam logic [c_PH_W-1:0]  c_PH_STUCK  = c_PH_W'(4 * CLKS_PER_US - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_STOP  = c_BIT_W'(NUM_BITS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FALL = 3'd1,
        S_SAMPLE    = 3'd2,
        S_WAIT_RISE = 3'd3,
        S_DONE      = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_sync1, r_line, r_line_d;
    logic                  w_fall;
    logic [c_TMO_W-1:0]    r_tmo_cnt, w_tmo_nxt;
    logic [c_PH_W-1:0]     r_phase, w_phase_nxt;
    logic [c_BIT_W-1:0]    r_bit_cnt, w_bit_nxt;
    logic [NUM_BITS-1:0]   r_shift, w_shift_nxt;
    logic                  w_load;

    // The line idles high, so the synchronizer resets to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_line   <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= controller_signal;
            r_line   <= r_sync1;
            r_line_d <= r_line;
        end
    end

    assign w_fall = r_line_d & ~r_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo_cnt <= w_tmo_nxt;
            r_phase   <= w_phase_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            if (w_load) begin
                rx_data <= r_shift;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo_cnt;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        rx_valid    = (r_state == S_DONE);
        rx_err      = (r_state == S_ERR);
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_state_nxt = S_WAIT_FALL;
                    w_tmo_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_shift_nxt = '0;
                end
            end
            S_WAIT_FALL: begin
                if (w_fall) begin
                    w_state_nxt = S_SAMPLE;
                    w_phase_nxt = '0;
                end else if (r_tmo_cnt == c_TMO_MAX) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
                end
            end
            S_SAMPLE: begin
                w_phase_nxt = r_phase + 1'b1;
                if (r_phase == c_PH_SAMPLE) begin
                    if (r_bit_cnt != c_BIT_STOP) begin
                        w_shift_nxt = {r_shift[NUM_BITS-2:0], r_line};
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                        w_state_nxt = S_WAIT_RISE;
                    end else if (r_line) begin
                        // Load here so rx_data is already valid while rx_valid is high.
                        w_load      = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
            end
            S_WAIT_RISE: begin
                if (r_line) begin
                    w_state_nxt = S_WAIT_FALL;
                    w_tmo_nxt   = '0;
                end else if (r_phase == c_PH_STUCK) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef N64_RX_FIELDS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons <= '0;
            stick_x <= '0;
            stick_y <= '0;
        end else if (w_load) begin
            buttons <= r_shift[31:16];
            stick_x <= r_shift[15:8];
            stick_y <= r_shift[7:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_n64_response_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_n64_response_receiver                                                 |
// | Directed + random reply frames checked against a bit-level reply model.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_n64_response_receiver;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        line_in = 1'b1;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic        busy;
`ifdef N64_RX_FIELDS_EN
    logic [15:0] buttons;
    logic [7:0]  stick_x;
    logic [7:0]  stick_y;
`endif

    n64_response_receiver #(
        .CLKS_PER_US (C),
        .NUM_BITS    (32),
        .TIMEOUT_US  (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .arm               (arm),
        .controller_signal (line_in),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_err            (rx_err),
        .busy              (busy)
`ifdef N64_RX_FIELDS_EN
        ,
        .buttons           (buttons),
        .stick_x           (stick_x),
        .stick_y           (stick_y)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    int          busy_cyc = 0;
    logic [31:0] exp_data = 32'h0;

    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (rx_err)   err_cnt++;
        if (busy)     busy_cyc++;
        if (rx_valid || rx_err) begin
            n_cmp++;
            assert (!(rx_valid && rx_err)) else begin
                n_bad++;
                $error("FAIL excl: observed valid=%0b err=%0b expected never both", rx_valid, rx_err);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish expected finish within 5 ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Controller bit: 0 = 3 us low / 1 us high, 1 = 1 us low / 3 us high.
    task automatic send_bit(input logic b);
        line_in = 1'b0;
        repeat (b ? C : 3 * C) @(negedge clk);
        line_in = 1'b1;
        repeat (b ? 3 * C : C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic stop);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
        send_bit(stop);
    endtask

    task automatic do_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, busy}, 32'h0);
    endtask

    // Reference: a frame is accepted iff its stop bit is 1; accepted word replaces rx_data.
    task automatic run_frame(input string tag, input logic [31:0] w, input logic stop);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        do_arm();
        send_frame(w, stop);
        repeat (4) @(negedge clk);
        wait_idle({tag, "_idle"});
        if (stop) exp_data = w;
        check({tag, "_valid"}, valid_cnt - v0, stop ? 32'd1 : 32'd0);
        check({tag, "_err"},   err_cnt - e0,   stop ? 32'd0 : 32'd1);
        check({tag, "_data"},  rx_data,        exp_data);
    endtask

    initial begin
        int          n, v0, e0, b0;
        logic [31:0] w;
        logic        s;

        repeat (3) @(negedge clk);
        check("rst_data",  rx_data, 32'h0);
        check("rst_valid", {31'b0, rx_valid}, 32'h0);
        check("rst_err",   {31'b0, rx_err}, 32'h0);
        check("rst_busy",  {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_frame("good", 32'h8000_7F81, 1'b1);
`ifdef N64_RX_FIELDS_EN
        check("buttons", {16'h0, buttons}, 32'h0000_8000);
        check("stick_x", {24'h0, stick_x}, 32'h0000_007F);
        check("stick_y", {24'h0, stick_y}, 32'h0000_0081);
`endif

        // Timeout: error exactly 32 cycles after the arming edge.
        e0 = err_cnt;
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        n = 0;
        while (!rx_err && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycle", n, 32'd32);
        @(negedge clk);
        check("tmo_busy", {31'b0, busy}, 32'h0);
        check("tmo_errcnt", err_cnt - e0, 32'd1);
        check("tmo_data", rx_data, exp_data);

        run_frame("framing", $urandom, 1'b0);

        // Stuck low: line held low 6 us after the 5th fall.
        v0 = valid_cnt;
        e0 = err_cnt;
        do_arm();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        line_in = 1'b0;
        repeat (6 * C) @(negedge clk);
        line_in = 1'b1;
        repeat (4 * C) @(negedge clk);
        wait_idle("stuck_idle");
        check("stuck_err",   err_cnt - e0, 32'd1);
        check("stuck_valid", valid_cnt - v0, 32'd0);
        check("stuck_data",  rx_data, exp_data);

        for (int k = 0; k < 6; k++) begin
            w = $urandom;
            s = ($urandom_range(0, 3) != 0);
            run_frame("rand", w, s);
        end
        run_frame("ones", 32'hFFFF_FFFF, 1'b1);

        // Edges without arm must be ignored.
        v0 = valid_cnt;
        e0 = err_cnt;
        b0 = busy_cyc;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        repeat (4) @(negedge clk);
        check("noarm_busy",  busy_cyc - b0, 32'd0);
        check("noarm_pulse", (valid_cnt - v0) + (err_cnt - e0), 32'd0);
        check("noarm_data",  rx_data, exp_data);

        // Reset mid-reply, then a clean all-zero reply.
        v0 = valid_cnt;
        e0 = err_cnt;
        do_arm();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        line_in = 1'b0;
        repeat (C) @(negedge clk);
        rst_n = 1'b0;
        exp_data = 32'h0;
        @(negedge clk);
        check("midrst_data", rx_data, exp_data);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        line_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_pulse", (valid_cnt - v0) + (err_cnt - e0), 32'd0);
        run_frame("zero", 32'h0000_0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
